// File: rtl/instruction_fetch_unit_pkg.sv
// Shared LEGv8 definitions: PC-select encodings, fetch FSM states, reset PC.
// IFU_MISALIGN_TRAP_EN adds the HALT state for misaligned next-PC traps.
package instruction_fetch_unit_pkg;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BR     = 2'b10;
  localparam logic [1:0] PS_BRANCH = 2'b11;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC1 = 2'b01,
`ifdef IFU_MISALIGN_TRAP_EN
    EXEC2 = 2'b10,
    HALT  = 2'b11
`else
    EXEC2 = 2'b10
`endif
  } ifu_state_e;

  function automatic logic pc_misaligned(input logic [63:0] pc);
    return |(pc & 64'd3);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Combinational next-PC selection (hold, PC+4, register target, PC-relative branch).
// Alignment handling (IFU_MISALIGN_TRAP_EN) is left to the instantiating fetch unit.
module pc_next_logic
  import instruction_fetch_unit_pkg::*;
(
  input  logic [63:0] PC,
  input  logic [1:0]  PS,
  input  logic        EN_PC,
  input  logic [63:0] K,
  input  logic [63:0] pc_in,
  output logic [63:0] next_pc
);

  logic [63:0] pc_plus4_s;

  assign pc_plus4_s = PC + 64'd4;

  // Select the candidate PC; K is a word offset, hence the shift by two
  always_comb begin
    next_pc = PC;
    if (EN_PC) begin
      case (PS)
        PS_HOLD:   next_pc = PC;
        PS_INC:    next_pc = pc_plus4_s;
        PS_BR:     next_pc = pc_in;
        PS_BRANCH: next_pc = pc_plus4_s + (K << 2);
        default:   next_pc = PC;
      endcase
    end else begin
      next_pc = PC;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// LEGv8 instruction fetch unit: FETCH / EXEC1 / EXEC2 sequencing and PC register.
// Define IFU_MISALIGN_TRAP_EN to trap misaligned next-PC values into HALT.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  PS,
  input  logic        EN_PC,
  input  logic        NS,
  input  logic [63:0] K,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] PC,
  output logic [63:0] PC4
);

  ifu_state_e  state_r;
  ifu_state_e  state_s;
  logic [63:0] pc_r;
  logic [31:0] instr_r;
  logic        imem_req_r;
  logic        instr_valid_r;
  logic [63:0] pc_calc_s;
  logic [63:0] pc_next_s;
  logic        pc_update_s;
  logic        pc_load_s;
  logic        fetch_done_s;

  pc_next_logic u_pc_next_logic (
    .PC      (pc_r),
    .PS      (PS),
    .EN_PC   (EN_PC),
    .K       (K),
    .pc_in   (pc_in),
    .next_pc (pc_calc_s)
  );

  // Only a request we actually have outstanding can complete a fetch
  assign fetch_done_s = (state_r == FETCH) && imem_req_r && imem_valid;

  // Next-state and PC-load decision
  always_comb begin
    state_s     = state_r;
    pc_update_s = 1'b0;
    pc_load_s   = 1'b0;
    pc_next_s   = pc_calc_s & ~64'd3;
    case (state_r)
      FETCH: begin
        if (fetch_done_s) state_s = EXEC1;
        else              state_s = FETCH;
      end
      EXEC1: begin
        if (NS) begin
          state_s = EXEC2;
        end else begin
          state_s     = FETCH;
          pc_update_s = 1'b1;
        end
      end
      EXEC2: begin
        state_s     = FETCH;
        pc_update_s = 1'b1;
      end
`ifdef IFU_MISALIGN_TRAP_EN
      HALT:    state_s = HALT;
`endif
      default: state_s = FETCH;
    endcase
`ifdef IFU_MISALIGN_TRAP_EN
    pc_next_s = pc_calc_s;
    if (pc_update_s && pc_misaligned(pc_calc_s)) begin
      state_s   = HALT;
      pc_load_s = 1'b0;
    end else begin
      pc_load_s = pc_update_s;
    end
`else
    pc_load_s = pc_update_s;
`endif
  end

  // State, PC, instruction register and registered handshake outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (pc_load_s)    pc_r    <= pc_next_s;
      if (fetch_done_s) instr_r <= imem_rdata;
      imem_req_r    <= (state_s == FETCH);
      instr_valid_r <= (state_s == EXEC1) || (state_s == EXEC2);
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instruction = instr_r;
  assign instr_valid = instr_valid_r;
  assign PC          = pc_r;
  assign PC4         = pc_r + 64'd4;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit (default RESET_PC = 0).
// Expectations for the 0x2003 target follow IFU_MISALIGN_TRAP_EN when defined.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  PS = 2'b00;
  logic        EN_PC = 1'b0;
  logic        NS = 1'b0;
  logic [63:0] K = 64'h0;
  logic [63:0] pc_in = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_valid = 1'b0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] PC;
  logic [63:0] PC4;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .PS          (PS),
    .EN_PC       (EN_PC),
    .NS          (NS),
    .K           (K),
    .pc_in       (pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PC4         (PC4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] instr;
    int          delay;
    logic        ns;
    logic [1:0]  ps;
    logic        en;
    logic [63:0] k;
    logic [63:0] target;
    logic [63:0] addr;
    logic [63:0] exp_pc;
    logic        halt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One full instruction: fetch with v.delay wait cycles, execute, then check the PC update
  task automatic do_instr(input vec_t v);
    for (int i = 0; i < v.delay; i++) begin
      check("wait_req", 64'(imem_req), 64'd1);
      check("wait_addr", imem_addr, v.addr);
      imem_valid = 1'b0;
      @(negedge clock);
    end
    check("fetch_req", 64'(imem_req), 64'd1);
    check("fetch_addr", imem_addr, v.addr);
    check("fetch_iv", 64'(instr_valid), 64'd0);
    imem_valid = 1'b1;
    imem_rdata = v.instr;
    @(negedge clock);
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    check("exec1_iv", 64'(instr_valid), 64'd1);
    check("exec1_req", 64'(imem_req), 64'd0);
    check("exec1_instr", 64'(instruction), 64'(v.instr));
    check("exec1_pc4", PC4, v.addr + 64'd4);
    NS = v.ns; PS = v.ps; EN_PC = v.en; K = v.k; pc_in = v.target;
    @(negedge clock);
    if (v.ns) begin
      check("exec2_iv", 64'(instr_valid), 64'd1);
      check("exec2_instr", 64'(instruction), 64'(v.instr));
      check("exec2_pc_held", PC, v.addr);
      NS = 1'b0;
      @(negedge clock);
    end
    check("after_pc", PC, v.exp_pc);
    check("after_iv", 64'(instr_valid), 64'd0);
    check("after_req", 64'(imem_req), v.halt ? 64'd0 : 64'd1);
    NS = 1'b0; PS = 2'b00; EN_PC = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h8B020020, 2, 1'b0, 2'b01, 1'b1, 64'h0, 64'h0, 64'h0, 64'h4, 1'b0};
    vecs[1] = '{32'hAAAA0001, 0, 1'b0, 2'b10, 1'b1, 64'h0, 64'h100, 64'h4, 64'h100, 1'b0};
    vecs[2] = '{32'h12345678, 1, 1'b0, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h100, 64'hFC, 1'b0};
    vecs[3] = '{32'hCAFEF00D, 0, 1'b1, 2'b01, 1'b1, 64'h0, 64'h0, 64'hFC, 64'h100, 1'b0};
    vecs[4] = '{32'h11112222, 0, 1'b0, 2'b01, 1'b0, 64'h0, 64'h0, 64'h100, 64'h100, 1'b0};
    vecs[5] = '{32'h33334444, 0, 1'b0, 2'b00, 1'b1, 64'h0, 64'h0, 64'h100, 64'h100, 1'b0};
    vecs[6] = '{32'h55556666, 0, 1'b0, 2'b10, 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[7] = '{32'h77778888, 1, 1'b0, 2'b01, 1'b1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0};
    vecs[8] = '{32'h9999AAAA, 0, 1'b1, 2'b11, 1'b1, 64'h1, 64'h0, 64'h0, 64'h8, 1'b0};
`ifdef IFU_MISALIGN_TRAP_EN
    vecs[9] = '{32'hBBBBCCCC, 0, 1'b0, 2'b10, 1'b1, 64'h0, 64'h2003, 64'h8, 64'h8, 1'b1};
`else
    vecs[9] = '{32'hBBBBCCCC, 0, 1'b0, 2'b10, 1'b1, 64'h0, 64'h2003, 64'h8, 64'h2000, 1'b0};
`endif

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_iv", 64'(instr_valid), 64'd0);
    check("rst_pc", PC, 64'h0);
    check("rst_instr", 64'(instruction), 64'd0);
    check("rst_pc4", PC4, 64'h4);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) do_instr(vecs[i]);

`ifdef IFU_MISALIGN_TRAP_EN
    // HALT persists with request and execute both idle
    imem_valid = 1'b1;
    repeat (3) @(negedge clock);
    imem_valid = 1'b0;
    check("halt_req", 64'(imem_req), 64'd0);
    check("halt_iv", 64'(instr_valid), 64'd0);
    check("halt_pc", PC, 64'h8);
`endif

    // Reset during a pending fetch, late imem_valid after release must be dropped
    imem_valid = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    reset = 1'b0;
    @(negedge clock);
    check("rst2_pc", PC, 64'h0);
    check("rst2_req", 64'(imem_req), 64'd0);
    check("rst2_instr", 64'(instruction), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    imem_valid = 1'b0;
    check("late_valid_instr", 64'(instruction), 64'd0);
    check("late_valid_iv", 64'(instr_valid), 64'd0);
    check("refetch_req", 64'(imem_req), 64'd1);
    check("refetch_addr", imem_addr, 64'h0);
    do_instr('{32'h0F0F0F0F, 0, 1'b0, 2'b01, 1'b1, 64'h0, 64'h0, 64'h0, 64'h4, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
